// File: rtl/mouse_transmitter.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits + odd parity, stop, ACK.
// Latency: INHIBIT_CYCLES + REQ_CYCLES system cycles, then paced by 11 device clock falling edges.
// Backpressure: BUSY is high while a frame is in flight; SEND_BYTE outside IDLE is dropped.
//
// Ports:
//   CLK, RESET                       system clock, async active-high reset
//   CLK_MOUSE_IN, DATA_MOUSE_IN      sampled PS/2 clock/data lines
//   SEND_BYTE, BYTE_TO_SEND[7:0]     one-cycle transmit request and its byte
//   CLK_MOUSE_OUT_EN                 1 = pull PS/2 clock low
//   DATA_MOUSE_OUT, DATA_MOUSE_OUT_EN  data value / drive enable
//   BUSY, BYTE_SENT, TX_ERROR[1:0]   status: in flight, end pulse, {nack, timeout}
module mouse_transmitter #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int REQ_CYCLES     = 2000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       SEND_BYTE,
  input  logic [7:0] BYTE_TO_SEND,
  output logic       CLK_MOUSE_OUT_EN,
  output logic       DATA_MOUSE_OUT,
  output logic       DATA_MOUSE_OUT_EN,
  output logic       BUSY,
  output logic       BYTE_SENT,
  output logic [1:0] TX_ERROR
);

  localparam int MAX_A   = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  // Counters stop at N-1, so they never wrap before the compare.
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] REQ_LAST = CW'(REQ_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    REQ     = 3'd2,
    BITS    = 3'd3,
    STOP    = 3'd4,
    ACK     = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [8:0]      frame_q, frame_d;
  logic [1:0]      err_q, err_d;
  logic            clk_in_q, clk_in_d;
  logic            clk_en_q, clk_en_d;
  logic            data_en_q, data_en_d;
  logic            data_out_q, data_out_d;
  logic            busy_q, busy_d;
  logic            sent_q, sent_d;
  logic            fall;
  logic            waiting;

  // Previous sample vs. the live line: detection costs no extra cycle.
  assign fall     = clk_in_q & ~CLK_MOUSE_IN;
  assign clk_in_d = CLK_MOUSE_IN;
  assign waiting  = (state_q == BITS) || (state_q == STOP) ||
                    (state_q == ACK)  || (state_q == DONE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    frame_d    = frame_q;
    err_d      = err_q;
    sent_d     = 1'b0;
    data_out_d = data_out_q;

    case (state_q)
      IDLE: begin
        if (SEND_BYTE) begin
          frame_d = {~^BYTE_TO_SEND, BYTE_TO_SEND};
          err_d   = 2'b00;
          cnt_d   = '0;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d   = '0;
          state_d = REQ;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      REQ: begin
        if (cnt_q == REQ_LAST) begin
          cnt_d     = '0;
          bit_cnt_d = 4'd0;
          state_d   = BITS;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      BITS: begin
        if (fall) begin
          cnt_d      = '0;
          data_out_d = frame_q[bit_cnt_q];
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd8) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ACK: begin
        if (fall) begin
          cnt_d = '0;
          if (DATA_MOUSE_IN) err_d[1] = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        // Bus idle (both lines high) closes the transaction.
        if (CLK_MOUSE_IN && DATA_MOUSE_IN) begin
          sent_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Timeout overrides whatever the state logic decided this cycle,
    // including an edge or a NACK sample arriving at the same time.
    if (waiting && (cnt_q == TO_LAST)) begin
      err_d     = {err_q[1], 1'b1};
      sent_d    = 1'b1;
      cnt_d     = '0;
      bit_cnt_d = bit_cnt_q;
      state_d   = IDLE;
    end

    // Line controls follow the next state so they stay registered and aligned with it.
    clk_en_d  = (state_d == INHIBIT) || (state_d == REQ);
    data_en_d = (state_d == REQ) || (state_d == BITS) || (state_d == STOP);
    if (state_d == REQ) begin
      data_out_d = 1'b0;
    end else if (!data_en_d) begin
      data_out_d = 1'b1;
    end
    // Stays high through the end pulse so BUSY drops the cycle after it.
    busy_d = (state_d != IDLE) || sent_d;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= 4'd0;
      frame_q    <= 9'd0;
      err_q      <= 2'b00;
      clk_in_q   <= 1'b1;
      clk_en_q   <= 1'b0;
      data_en_q  <= 1'b0;
      data_out_q <= 1'b1;
      busy_q     <= 1'b0;
      sent_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      frame_q    <= frame_d;
      err_q      <= err_d;
      clk_in_q   <= clk_in_d;
      clk_en_q   <= clk_en_d;
      data_en_q  <= data_en_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      sent_q     <= sent_d;
    end
  end

  assign CLK_MOUSE_OUT_EN  = clk_en_q;
  assign DATA_MOUSE_OUT    = data_out_q;
  assign DATA_MOUSE_OUT_EN = data_en_q;
  assign BUSY              = busy_q;
  assign BYTE_SENT         = sent_q;
  assign TX_ERROR          = err_q;

endmodule

// File: doc/mouse_transmitter.md
MOUSE_TRANSMITTER -- requirements
Module: mouse_transmitter

Interface
REQ-001 Parameters SHALL be:
- INHIBIT_CYCLES, default 12000: CLK cycles the clock line is held low (120 us at 100 MHz).
- REQ_CYCLES, default 2000: CLK cycles data and clock are both held low before the clock is released.
- TIMEOUT_CYCLES, default 100000: maximum CLK cycles to wait for a device clock event (1 ms).

REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK, in, 1: system clock (100 MHz).
- RESET, in, 1: asynchronous, active-high reset.
- CLK_MOUSE_IN, in, 1: sampled PS/2 clock line.
- DATA_MOUSE_IN, in, 1: sampled PS/2 data line.
- SEND_BYTE, in, 1: one-cycle request to transmit.
- BYTE_TO_SEND, in, 8: byte to transmit; valid with SEND_BYTE.
- CLK_MOUSE_OUT_EN, out, 1: 1 = pull the clock line low; 0 = release it.
- DATA_MOUSE_OUT, out, 1: value driven on the data line when enabled.
- DATA_MOUSE_OUT_EN, out, 1: 1 = drive the data line; 0 = release it.
- BUSY, out, 1: high from request acceptance until return to IDLE.
- BYTE_SENT, out, 1: one-cycle pulse when a transaction ends, whether completed or aborted.
- TX_ERROR, out, 2: bit0 = timeout; bit1 = device NACK. Held until the next accepted request.

Function
REQ-003 The block SHALL register CLK_MOUSE_IN once per CLK; a falling edge SHALL be detected as previous=1 and current=0.
REQ-004 States SHALL be IDLE, INHIBIT, REQ, BITS, STOP, ACK, DONE.
REQ-005 IDLE: both lines released, BUSY=0. On SEND_BYTE=1:
- latch frame = {odd-parity bit, BYTE_TO_SEND} (parity = ~^BYTE_TO_SEND);
- clear TX_ERROR and the cycle counter;
- go to INHIBIT with BUSY=1 from the next cycle.
REQ-006 SEND_BYTE outside IDLE SHALL be ignored, and the latched frame SHALL NOT change.
REQ-007 INHIBIT: CLK_MOUSE_OUT_EN=1, DATA_MOUSE_OUT_EN=0. After INHIBIT_CYCLES cycles, go to REQ and reset the counter.
REQ-008 REQ: CLK_MOUSE_OUT_EN=1, DATA_MOUSE_OUT_EN=1, DATA_MOUSE_OUT=0 (start bit). After REQ_CYCLES cycles, go to BITS with the bit counter at 0.
REQ-009 BITS: CLK_MOUSE_OUT_EN=0, data driven. On falling edge n (n = 1..9), DATA_MOUSE_OUT SHALL take frame bit n-1, LSB first, with parity as the 9th bit. After the 9th edge, go to STOP.
REQ-010 STOP: on the next falling edge, release data (DATA_MOUSE_OUT_EN=0, DATA_MOUSE_OUT=1) and go to ACK.
REQ-011 ACK: on the next falling edge, sample DATA_MOUSE_IN; if it is 1, set TX_ERROR[1]. Go to DONE.
REQ-012 DONE: when CLK_MOUSE_IN=1 and DATA_MOUSE_IN=1 in the same cycle, pulse BYTE_SENT for one cycle and go to IDLE. BUSY SHALL fall in the cycle after the pulse.
REQ-013 In BITS, STOP, ACK and DONE, the timeout counter SHALL clear on every falling edge (DONE: on every state entry) and increment otherwise. On reaching TIMEOUT_CYCLES:
- set TX_ERROR[0];
- release both lines;
- pulse BYTE_SENT;
- go to IDLE.
REQ-014 Timeout SHALL take priority over an edge arriving in the same cycle.
REQ-015 The bit counter SHALL be 4 bits; the counters SHALL be wide enough for the largest parameter; no wrap-around SHALL occur before the compare.
REQ-016 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-017 The unused default state SHALL recover to IDLE with lines released in one cycle.

Reset
REQ-018 On RESET=1, asynchronously:
- state=IDLE;
- CLK_MOUSE_OUT_EN=0, DATA_MOUSE_OUT_EN=0, DATA_MOUSE_OUT=1;
- BUSY=0, BYTE_SENT=0, TX_ERROR=00;
- counters=0, frame=0;
- edge register=1.
REQ-019 Reset mid-transaction SHALL release both lines immediately and SHALL NOT produce a BYTE_SENT pulse.

Verification
(Bench parameters: INHIBIT_CYCLES=10, REQ_CYCLES=4, TIMEOUT_CYCLES=50; the device model clocks 11 falling edges at a 40-cycle period.)
REQ-020 SEND_BYTE with 0xF4, device ACK 0 -> 10 cycles of clock low, start bit 0, data bits 0,0,1,0,1,1,1,1, parity 0, stop release; BYTE_SENT pulse; TX_ERROR=00.
REQ-021 SEND_BYTE with 0x00, then 0xFF -> parity bit 1 in both frames; TX_ERROR=00.
REQ-022 Send 0xF4 with the device leaving data high at the ACK edge -> TX_ERROR=10, one BYTE_SENT pulse.
REQ-023 Device stops clocking after edge 5 -> 50 cycles later TX_ERROR=01, BYTE_SENT pulse, both lines released.
REQ-024 SEND_BYTE with 0x55 during BITS of a 0xF4 transfer -> the 0xF4 frame is unchanged; exactly one BYTE_SENT pulse.
REQ-025 RESET asserted during BITS -> next cycle all enables are 0, BUSY=0, no BYTE_SENT; a subsequent 0xF4 send completes normally.
